// File: rtl/mask_decoder_5_32_pkg.sv
// Shared types and constants for the 5-to-32 mask decoder.
package lp_dec_pkg;
    localparam int IDX_W = 5;
    localparam int OUT_W = 32;

    typedef logic [OUT_W-1:0] mask_t;

    typedef enum logic [1:0] {
        OP_ONEHOT = 2'b00,
        OP_THERM  = 2'b01,
        OP_ACC    = 2'b10,
        OP_CLR    = 2'b11
    } op_t;

    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_OPEN = 1'b1
    } acc_state_t;

    // Bits [idx:0] set; onehot-1 stays in 32 bits so idx=31 cannot overflow.
    function automatic mask_t therm_of(input mask_t onehot);
        return onehot | (onehot - mask_t'(1));
    endfunction
endpackage

// File: rtl/mask_decoder_5_32_dec.sv
// Purely combinational 5-bit index to 32-bit one-hot decoder.
module dec_5_32
    import lp_dec_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [OUT_W-1:0] onehot
);
    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi++) begin : g_bit
            assign onehot[gi] = (idx == IDX_W'(gi));
        end
    endgenerate
endmodule

// File: rtl/mask_decoder_5_32.sv
// Registered, handshaked 5-to-32 decoder producing one-hot, thermometer or accumulated masks.
// Optional duplicate-index detection on accumulation is enabled by MASK_DEC_DUP_CHECK_EN.
module mask_decoder_5_32
    import lp_dec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_idx,
    input  logic [1:0]  in_op,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_mask,
    output logic        acc_open,
    output logic        err_dup
);
    mask_t      onehot;
    mask_t      acc_reg;
    mask_t      out_mask_reg;
    logic       out_valid_reg;
    acc_state_t state_reg;
    logic       accept;
    op_t        op;

    dec_5_32 u_dec (
        .idx    (in_idx),
        .onehot (onehot)
    );

    assign op       = op_t'(in_op);
    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    assign out_valid = out_valid_reg;
    assign out_mask  = out_mask_reg;
    assign acc_open  = (state_reg == ACC_OPEN);

`ifdef MASK_DEC_DUP_CHECK_EN
    logic err_dup_reg;
    assign err_dup = err_dup_reg;
`else
    assign err_dup = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_mask_reg  <= '0;
            acc_reg       <= '0;
            state_reg     <= ACC_IDLE;
`ifdef MASK_DEC_DUP_CHECK_EN
            err_dup_reg   <= 1'b0;
`endif
        end else begin
            // A load in the same cycle overrides this drop.
            if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (accept) begin
                case (op)
                    OP_ONEHOT: begin
                        out_mask_reg  <= onehot;
                        out_valid_reg <= 1'b1;
                    end
                    OP_THERM: begin
                        out_mask_reg  <= therm_of(onehot);
                        out_valid_reg <= 1'b1;
                    end
                    OP_ACC: begin
`ifdef MASK_DEC_DUP_CHECK_EN
                        if ((acc_reg & onehot) != '0) begin
                            err_dup_reg <= 1'b1;
                        end
`endif
                        if (in_last) begin
                            out_mask_reg  <= acc_reg | onehot;
                            out_valid_reg <= 1'b1;
                            acc_reg       <= '0;
                            state_reg     <= ACC_IDLE;
                        end else begin
                            acc_reg   <= acc_reg | onehot;
                            state_reg <= ACC_OPEN;
                        end
                    end
                    OP_CLR: begin
                        acc_reg   <= '0;
                        state_reg <= ACC_IDLE;
`ifdef MASK_DEC_DUP_CHECK_EN
                        err_dup_reg <= 1'b0;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mask_decoder_5_32.sv
// Directed bench for mask_decoder_5_32 with an expected-output scoreboard queue.
module tb_mask_decoder_5_32;
    import lp_dec_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_idx = '0;
    logic [1:0]  in_op = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_mask;
    logic        acc_open;
    logic        err_dup;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] model_acc = '0;
`ifdef MASK_DEC_DUP_CHECK_EN
    localparam logic DUP_EXP = 1'b1;
`else
    localparam logic DUP_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    mask_decoder_5_32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_op     (in_op),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .acc_open  (acc_open),
        .err_dup   (err_dup)
    );

    // Scoreboard: every output handshake pops and compares one expected mask.
    always @(negedge clk) begin
        logic [31:0] exp_m;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $error("FAIL out_unexpected: observed %h required no output", out_mask);
            end else begin
                exp_m = sb_q.pop_front();
                $display("out mask=%h expected=%h", out_mask, exp_m);
                assert (out_mask === exp_m) else begin
                    errors++;
                    $error("FAIL out_mask: observed %h required %h", out_mask, exp_m);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        $display("check %s observed=%h expected=%h", tag, obs, exp_v);
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] model_therm(input logic [4:0] idx);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i <= int'(idx); i++) m[i] = 1'b1;
        return m;
    endfunction

    // Drives one beat from posedge+1 and holds it until accepted.
    task automatic send(input op_t op, input logic [4:0] idx, input logic last);
        logic ok;
        logic produces;
        int   n;
        logic [31:0] bit_m;
        bit_m = 32'h1 << idx;
        produces = 1'b0;
        case (op)
            OP_ONEHOT: begin sb_q.push_back(bit_m); produces = 1'b1; end
            OP_THERM:  begin sb_q.push_back(model_therm(idx)); produces = 1'b1; end
            OP_ACC: begin
                if (last) begin
                    sb_q.push_back(model_acc | bit_m);
                    model_acc = '0;
                    produces = 1'b1;
                end else begin
                    model_acc = model_acc | bit_m;
                end
            end
            default: model_acc = '0;
        endcase
        in_valid = 1'b1; in_op = op; in_idx = idx; in_last = last;
        ok = 1'b0; n = 0;
        while (!ok && n < 50) begin
            ok = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'(ok), 32'h1);
        else if (out_ready) chk("latency_valid", 32'(out_valid), 32'(produces));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst = 1'b1;
        cycles(2);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_mask", out_mask, 32'h0);
        chk("rst_acc_open", 32'(acc_open), 32'h0);
        chk("rst_err_dup", 32'(err_dup), 32'h0);
        rst = 1'b0;
        cycles(1);

        // Back-to-back one-hot and thermometer beats
        send(OP_ONEHOT, 5'd0, 1'b0);
        send(OP_ONEHOT, 5'd5, 1'b0);
        send(OP_ONEHOT, 5'd31, 1'b0);
        send(OP_THERM, 5'd0, 1'b0);
        send(OP_THERM, 5'd7, 1'b0);
        send(OP_THERM, 5'd31, 1'b0);
        cycles(1);

        // Accumulation burst
        send(OP_ACC, 5'd3, 1'b0);
        chk("acc_open_after_first", 32'(acc_open), 32'h1);
        send(OP_ACC, 5'd1, 1'b0);
        send(OP_ONEHOT, 5'd12, 1'b0);
        chk("acc_open_during_onehot", 32'(acc_open), 32'h1);
        send(OP_ACC, 5'd30, 1'b1);
        chk("acc_open_after_last", 32'(acc_open), 32'h0);
        send(OP_ACC, 5'd0, 1'b1);
        cycles(1);

        // Backpressure: hold, then swap in a pending beat with no bubble
        out_ready = 1'b0;
        send(OP_ONEHOT, 5'd4, 1'b0);
        chk("bp_out_valid", 32'(out_valid), 32'h1);
        chk("bp_in_ready", 32'(in_ready), 32'h0);
        sb_q.push_back(32'h7);
        in_valid = 1'b1; in_op = OP_THERM; in_idx = 5'd2; in_last = 1'b0;
        cycles(3);
        chk("bp_hold_mask", out_mask, 32'h10);
        chk("bp_hold_in_ready", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        cycles(1);
        in_valid = 1'b0;
        chk("bp_swap_valid", 32'(out_valid), 32'h1);
        chk("bp_swap_mask", out_mask, 32'h7);
        cycles(2);

        // Reset mid-burst discards the partial accumulator
        send(OP_ACC, 5'd9, 1'b0);
        chk("mid_acc_open", 32'(acc_open), 32'h1);
        rst = 1'b1;
        model_acc = '0;
        cycles(1);
        rst = 1'b0;
        chk("mid_rst_acc_open", 32'(acc_open), 32'h0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        send(OP_ACC, 5'd1, 1'b1);
        cycles(1);

        // Duplicate index handling
        send(OP_ACC, 5'd6, 1'b0);
        chk("dup_first", 32'(err_dup), 32'h0);
        send(OP_ACC, 5'd6, 1'b0);
        chk("dup_second", 32'(err_dup), 32'(DUP_EXP));
        send(OP_ACC, 5'd2, 1'b1);
        chk("dup_sticky", 32'(err_dup), 32'(DUP_EXP));
        send(OP_CLR, 5'd0, 1'b0);
        chk("dup_clr", 32'(err_dup), 32'h0);
        chk("clr_acc_open", 32'(acc_open), 32'h0);

        // CLR mid-burst drops partial bits
        send(OP_ACC, 5'd20, 1'b0);
        send(OP_CLR, 5'd0, 1'b0);
        chk("clr_mid_acc_open", 32'(acc_open), 32'h0);
        send(OP_ACC, 5'd8, 1'b1);
        cycles(3);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running required finished");
        $fatal(1, "timeout");
    end
endmodule
